// File: rtl/bit_window_packer_pkg.sv
// Shared widths, limits and FSM state encoding for the bit window packer.
package pack_defs;
  localparam int WORD_W = 32;
  localparam int LINE_W = 512;
  localparam int PTR_W  = 9;
  localparam int LEN_W  = 6;
  localparam int BITS_W = 10;
  localparam int TMR_W  = 7;
  localparam logic [TMR_W-1:0] TIMEOUT = 7'd127;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_EMIT = 1'b1
  } state_e;
endpackage

// File: rtl/bit_window_packer_bit_insert.sv
// Combinational merge of one LSB-aligned field into the line/spill pair at bit offset wp.
// This is the only place that does bit-offset arithmetic.
module bit_insert
  import pack_defs::*;
(
  input  logic [LINE_W-1:0] line_i,
  input  logic [WORD_W-1:0] spill_i,
  input  logic [PTR_W-1:0]  wp_i,
  input  logic [WORD_W-1:0] data_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic [LINE_W-1:0] line_o,
  output logic [WORD_W-1:0] spill_o,
  output logic [PTR_W:0]    sum_o
);
  logic [LEN_W-1:0]         len_c;
  logic [WORD_W-1:0]        mask;
  logic [LINE_W+WORD_W-1:0] shifted;

  // Mask the field, shift it to wp, split across line and spill.
  always_comb begin
    len_c   = (len_i > 6'd32) ? 6'd32 : len_i;
    mask    = (len_c == 6'd32) ? {WORD_W{1'b1}} : ((32'd1 << len_c) - 32'd1);
    shifted = {{LINE_W{1'b0}}, data_i & mask} << wp_i;
    line_o  = line_i | shifted[LINE_W-1:0];
    spill_o = spill_i | shifted[LINE_W+WORD_W-1:LINE_W];
    sum_o   = {1'b0, wp_i} + {4'b0000, len_c};
  end
endmodule

// File: rtl/bit_window_packer.sv
// Packs 0..32-bit fields LSB-first into 512-bit lines emitted over valid/ready.
// Optional idle-timeout flush of partial lines: define PACK_TIMEOUT_FLUSH_EN.
module bit_window_packer
  import pack_defs::*;
(
  input  logic              sysclk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic [LEN_W-1:0]  in_len,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LINE_W-1:0] out_line,
  output logic [BITS_W-1:0] out_bits
);
  state_e              state_q, state_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [WORD_W-1:0]   spill_q, spill_d;
  logic [PTR_W-1:0]    wp_q, wp_d;
  logic [PTR_W-1:0]    pending_q, pending_d;
  logic                last_pend_q, last_pend_d;
  logic [LINE_W-1:0]   out_line_q, out_line_d;
  logic [BITS_W-1:0]   out_bits_q, out_bits_d;
  logic [LINE_W-1:0]   ins_line;
  logic [WORD_W-1:0]   ins_spill;
  logic [PTR_W:0]      ins_sum;
  logic                accept;
  logic                flush;

  bit_insert u_insert (
    .line_i  (line_q),
    .spill_i (spill_q),
    .wp_i    (wp_q),
    .data_i  (in_data),
    .len_i   (in_len),
    .line_o  (ins_line),
    .spill_o (ins_spill),
    .sum_o   (ins_sum)
  );

  assign accept = in_valid & in_ready_q;

`ifdef PACK_TIMEOUT_FLUSH_EN
  logic [TMR_W-1:0] timer_q;

  // Idle timer: counts FILL cycles holding a partial line with no accept.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      timer_q <= '0;
    end else if (state_q == ST_EMIT || accept || wp_q == '0) begin
      timer_q <= '0;
    end else if (timer_q != TIMEOUT) begin
      timer_q <= timer_q + 7'd1;
    end else begin
      timer_q <= timer_q;
    end
  end

  assign flush = (state_q == ST_FILL) && in_ready_q && !accept &&
                 (wp_q != '0) && (timer_q == TIMEOUT);
`else
  assign flush = 1'b0;
`endif

  // State and registered handshake outputs.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_FILL;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Datapath registers.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      line_q      <= '0;
      spill_q     <= '0;
      wp_q        <= '0;
      pending_q   <= '0;
      last_pend_q <= 1'b0;
      out_line_q  <= '0;
      out_bits_q  <= '0;
    end else begin
      line_q      <= line_d;
      spill_q     <= spill_d;
      wp_q        <= wp_d;
      pending_q   <= pending_d;
      last_pend_q <= last_pend_d;
      out_line_q  <= out_line_d;
      out_bits_q  <= out_bits_d;
    end
  end

  // Next state: accept/flush in FILL, line recycle and pending spill in EMIT.
  always_comb begin
    state_d     = state_q;
    line_d      = line_q;
    spill_d     = spill_q;
    wp_d        = wp_q;
    pending_d   = pending_q;
    last_pend_d = last_pend_q;
    out_line_d  = out_line_q;
    out_bits_d  = out_bits_q;
    case (state_q)
      ST_FILL: begin
        if (accept) begin
          line_d  = ins_line;
          spill_d = ins_spill;
          if (ins_sum >= 10'd512) begin
            state_d     = ST_EMIT;
            out_line_d  = ins_line;
            out_bits_d  = 10'd512;
            pending_d   = PTR_W'(ins_sum - 10'd512);
            last_pend_d = in_last && (ins_sum != 10'd512);
          end else if (in_last && ins_sum != 10'd0) begin
            state_d     = ST_EMIT;
            wp_d        = PTR_W'(ins_sum);
            out_line_d  = ins_line;
            out_bits_d  = ins_sum;
            pending_d   = '0;
            last_pend_d = 1'b0;
          end else begin
            wp_d = PTR_W'(ins_sum);
          end
        end else if (flush) begin
          state_d     = ST_EMIT;
          out_line_d  = line_q;
          out_bits_d  = {1'b0, wp_q};
          pending_d   = '0;
          last_pend_d = 1'b0;
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          line_d  = {{(LINE_W-WORD_W){1'b0}}, spill_q};
          wp_d    = pending_q;
          spill_d = '0;
          // A flushed field that overflowed sends its spill as its own line.
          if (last_pend_q) begin
            state_d     = ST_EMIT;
            out_line_d  = {{(LINE_W-WORD_W){1'b0}}, spill_q};
            out_bits_d  = {1'b0, pending_q};
            pending_d   = '0;
            last_pend_d = 1'b0;
          end else begin
            state_d    = ST_FILL;
            out_line_d = '0;
          end
        end else begin
          state_d = ST_EMIT;
        end
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  // Output decode from the next state.
  always_comb begin
    in_ready_d  = (state_d == ST_FILL);
    out_valid_d = (state_d == ST_EMIT);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_line  = out_line_q;
  assign out_bits  = out_bits_q;
endmodule

// File: tb/tb_bit_window_packer.sv
// Self-checking bench: directed table rows, multi-cycle corner cases and a
// randomized run against a bit-queue reference model.
module tb_bit_window_packer;
  logic         sysclk, reset, in_valid, in_ready, in_last, out_valid, out_ready;
  logic [31:0]  in_data;
  logic [5:0]   in_len;
  logic [511:0] out_line;
  logic [9:0]   out_bits;

  typedef struct { logic [31:0] data; int len; int reps; int exp_bits; logic [63:0] exp_low; } vec_t;
  typedef struct { logic [511:0] line; int bits; } line_t;

  vec_t         tbl[6];
  bit           bits_q[$];
  line_t        exp_q[$];
  int           n_checks, n_fail, n_lines, last_bits, rdy_mode;
  logic [511:0] last_line, hold_line, exp1;

  bit_window_packer dut (
    .sysclk(sysclk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_len(in_len), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_line(out_line), .out_bits(out_bits)
  );

  initial begin
    sysclk = 1'b0;
    forever #5 sysclk = ~sysclk;
  end

  task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic fail_to(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got timeout required event", name);
  endtask

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  // Reference model: a plain bit stream cut into 512-bit lines.
  function automatic void emit_bits(input int n);
    line_t e;
    e.line = '0;
    for (int i = 0; i < n; i++) e.line[i] = bits_q.pop_front();
    e.bits = n;
    exp_q.push_back(e);
  endfunction

  function automatic void model_push(input logic [31:0] d, input int len, input bit last);
    for (int i = 0; i < len; i++) bits_q.push_back(d[i]);
    while (bits_q.size() >= 512) emit_bits(512);
    if (last && bits_q.size() > 0) emit_bits(bits_q.size());
  endfunction

  task automatic send(input logic [31:0] d, input int len, input bit last);
    bit acc = 1'b0;
    in_data = d; in_len = 6'(len); in_last = last; in_valid = 1'b1;
    for (int t = 0; t < 3000 && !acc; t++) begin
      @(negedge sysclk);
      if (in_ready) acc = 1'b1;
    end
    if (acc) model_push(d, len, last);
    else fail_to("send_accept");
    step();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_lines(input int target);
    for (int t = 0; t < 4000 && n_lines < target; t++) step();
    if (n_lines < target) fail_to("wait_lines");
  endtask

  task automatic wait_valid();
    bit seen = 1'b0;
    for (int t = 0; t < 4000 && !seen; t++) begin
      @(negedge sysclk);
      seen = out_valid;
    end
    if (!seen) fail_to("wait_out_valid");
  endtask

  task automatic monitor();
    line_t e;
    forever begin
      @(negedge sysclk);
      if (!reset && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          fail_to("unexpected_line");
        end else begin
          e = exp_q.pop_front();
          chk("line_bits", 512'(out_bits), 512'(e.bits));
          chk("line_data", out_line, e.line);
        end
        last_line = out_line;
        last_bits = int'(out_bits);
        n_lines++;
      end
    end
  endtask

  task automatic ready_drv();
    forever begin
      @(posedge sysclk);
      #1;
      case (rdy_mode)
        0: out_ready = 1'b0;
        1: out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  endtask

  initial begin
    int n0, cyc;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_len = '0; in_last = 1'b0;
    out_ready = 1'b1; rdy_mode = 1; n_checks = 0; n_fail = 0; n_lines = 0; last_bits = 0;
    tbl[0] = '{32'h000000A5, 8, 5, 40, 64'h000000A5A5A5A5A5};
    tbl[1] = '{32'h00000003, 4, 3, 12, 64'h0000000000000333};
    tbl[2] = '{32'h00000001, 1, 7, 7, 64'h000000000000007F};
    tbl[3] = '{32'h0000BEEF, 16, 2, 32, 64'h00000000BEEFBEEF};
    tbl[4] = '{32'h000FFFFF, 12, 2, 24, 64'h0000000000FFFFFF};
    tbl[5] = '{32'h0000000D, 3, 4, 12, 64'h0000000000000B6D};
    fork
      monitor();
      ready_drv();
    join_none

    repeat (3) @(posedge sysclk);
    @(negedge sysclk);
    chk("rst_out_valid", 512'(out_valid), 512'(0));
    chk("rst_in_ready", 512'(in_ready), 512'(0));
    chk("rst_out_bits", 512'(out_bits), 512'(0));
    chk("rst_out_line", out_line, 512'(0));
    step();
    reset = 1'b0;
    @(negedge sysclk);
    chk("start_in_ready_low", 512'(in_ready), 512'(0));
    @(negedge sysclk);
    chk("start_in_ready_high", 512'(in_ready), 512'(1));
    step();

    // Full line of 32-bit words.
    n0 = n_lines;
    exp1 = '0;
    for (int k = 0; k < 16; k++) begin
      send(32'(k), 32, 1'b0);
      exp1[32*k +: 32] = 32'(k);
    end
    wait_lines(n0 + 1);
    chk("full_bits", 512'(last_bits), 512'(512));
    chk("full_line", last_line, exp1);

    // Table rows, each closed by in_last.
    for (int r = 0; r < 6; r++) begin
      n0 = n_lines;
      for (int k = 0; k < tbl[r].reps; k++) send(tbl[r].data, tbl[r].len, k == tbl[r].reps - 1);
      wait_lines(n0 + 1);
      chk("tbl_bits", 512'(last_bits), 512'(tbl[r].exp_bits));
      chk("tbl_low", 512'(last_line[63:0]), 512'(tbl[r].exp_low));
      chk("tbl_upper_zero", 512'(last_line[511:64]), 512'(0));
    end

    // in_last with nothing buffered emits nothing.
    n0 = n_lines;
    send(32'h0, 0, 1'b1);
    repeat (5) step();
    chk("empty_last_no_emit", 512'(n_lines), 512'(n0));

    // Overflow spill carried into the next line.
    n0 = n_lines;
    send(32'h000ABCDE, 20, 1'b0);
    for (int k = 0; k < 15; k++) send(32'hC0DE0000 + 32'(k), 32, 1'b0);
    send(32'h13579BDF, 32, 1'b0);
    wait_lines(n0 + 1);
    chk("spill_first_bits", 512'(last_bits), 512'(512));
    chk("spill_first_low", 512'(last_line[19:0]), 512'(20'hABCDE));
    chk("spill_first_top", 512'(last_line[511:500]), 512'(12'hBDF));
    send(32'h0, 0, 1'b1);
    wait_lines(n0 + 2);
    chk("spill_wp_bits", 512'(last_bits), 512'(20));
    chk("spill_wp_data", last_line, 512'(20'h13579));

    // in_last overflowing the line: full line then the spill as its own line.
    n0 = n_lines;
    for (int k = 0; k < 15; k++) send(32'h5A5A5A5A, 32, 1'b0);
    send(32'h7FFFFFFF, 31, 1'b0);
    send(32'hFFFFFFFF, 32, 1'b1);
    wait_lines(n0 + 2);
    chk("last_spill_bits", 512'(last_bits), 512'(31));
    chk("last_spill_data", last_line, 512'(32'h7FFFFFFF));

    // Backpressure: line held stable while out_ready is low.
    rdy_mode = 0;
    for (int k = 0; k < 16; k++) send(32'hF00D0000 + 32'(k), 32, 1'b0);
    wait_valid();
    hold_line = out_line;
    for (int c = 0; c < 5; c++) begin
      @(negedge sysclk);
      chk("bp_out_valid", 512'(out_valid), 512'(1));
      chk("bp_in_ready", 512'(in_ready), 512'(0));
      chk("bp_line_stable", out_line, hold_line);
    end
    rdy_mode = 1;
    @(negedge sysclk);
    @(negedge sysclk);
    chk("bp_release_in_ready", 512'(in_ready), 512'(1));
    chk("bp_release_out_valid", 512'(out_valid), 512'(0));
    step();

    // Reset while a line waits in EMIT.
    rdy_mode = 0;
    for (int k = 0; k < 16; k++) send(32'hDEAD0000 + 32'(k), 32, 1'b0);
    wait_valid();
    step();
    reset = 1'b1;
    #1;
    chk("rst_emit_out_valid", 512'(out_valid), 512'(0));
    chk("rst_emit_out_bits", 512'(out_bits), 512'(0));
    bits_q.delete();
    exp_q.delete();
    repeat (2) step();
    reset = 1'b0;
    rdy_mode = 1;
    n0 = n_lines;
    exp1 = '0;
    for (int k = 0; k < 16; k++) begin
      send(32'h100 + 32'(k), 32, 1'b0);
      exp1[32*k +: 32] = 32'h100 + 32'(k);
    end
    wait_lines(n0 + 1);
    chk("post_rst_line", last_line, exp1);

    // Idle partial line.
    n0 = n_lines;
    send(32'h5, 3, 1'b0);
`ifdef PACK_TIMEOUT_FLUSH_EN
    model_push(32'h0, 0, 1'b1);
    cyc = 0;
    while (!out_valid && cyc < 400) begin
      @(negedge sysclk);
      cyc++;
    end
    chk("timeout_latency_ok", 512'(cyc >= 127 && cyc <= 130), 512'(1));
    step();
    wait_lines(n0 + 1);
    chk("timeout_bits", 512'(last_bits), 512'(3));
`else
    cyc = 0;
    repeat (300) step();
    chk("no_timeout_lines", 512'(n_lines), 512'(n0));
    chk("no_timeout_valid", 512'(out_valid), 512'(0));
    send(32'h0, 0, 1'b1);
    wait_lines(n0 + 1);
    chk("manual_flush_bits", 512'(last_bits), 512'(3));
`endif

    // Randomized fields with random backpressure against the model.
    rdy_mode = 2;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 3)) step();
      send($urandom, int'($urandom_range(0, 32)), $urandom_range(0, 9) == 0);
    end
    send(32'h0, 0, 1'b1);
    for (int t = 0; t < 4000 && exp_q.size() != 0; t++) step();
    chk("rand_drained", 512'(exp_q.size()), 512'(0));
    chk("rand_model_empty", 512'(bits_q.size()), 512'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
